vend_arbiter: RTL and testbench

VEND_ARBITER -- requirements
Module: vend_arbiter

---
 rtl/vend_arbiter_pkg.sv | 19 +
 rtl/vend_arbiter_lane.sv | 59 +++++
 rtl/vend_arbiter.sv | 135 +++++++++++++
 tb/tb_vend_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_arbiter_pkg.sv
// Shared definitions for the two-lane vending arbiter: FSM states, coin
// weights and default pricing/timeout parameters.
package vend_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    CHANGE,
    DONE
  } state_t;

  localparam int COIN5  = 1;
  localparam int COIN10 = 2;

  localparam int DEF_PRICE       = 3;
  localparam int DEF_MAX_CREDIT  = 4;
  localparam int DEF_ACK_TIMEOUT = 15;

endpackage

// File: rtl/vend_arbiter_lane.sv
// Per-lane coin accounting: credit register, pending flag and coin refusal.
// Credit is counted in 5-unit coins.
module vend_lane
  import vend_arbiter_pkg::*;
#(
  parameter int PRICE      = DEF_PRICE,
  parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in5,
  input  logic       in10,
  input  logic       clear,
  output logic [2:0] credit,
  output logic       pending,
  output logic       refuse
);

  logic [2:0] coin_add;
  logic [3:0] credit_new;
  logic       coin_seen;
  logic       accept;

  // Two coins in the same cycle are ambiguous, so neither is accepted.
  always_comb begin
    coin_add = '0;
    if (in5 && !in10) begin
      coin_add = 3'(COIN5);
    end else if (in10 && !in5) begin
      coin_add = 3'(COIN10);
    end
    coin_seen  = in5 || in10;
    credit_new = {1'b0, credit} + {1'b0, coin_add};
    accept     = coin_seen && !(in5 && in10) && !pending &&
                 (credit_new <= 4'(MAX_CREDIT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit  <= '0;
      pending <= 1'b0;
      refuse  <= 1'b0;
    end else begin
      refuse <= coin_seen && !accept;
      if (clear) begin
        credit  <= '0;
        pending <= 1'b0;
      end else begin
        if (accept) begin
          credit <= credit + coin_add;
        end
        if ({1'b0, credit} >= 4'(PRICE)) begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vend_arbiter.sv
// Two-lane vending arbiter: round-robin access to a shared dispenser and
// change unit, with an acknowledge timeout that raises a sticky fault.
module vend_arbiter
  import vend_arbiter_pkg::*;
#(
  parameter int PRICE       = DEF_PRICE,
  parameter int MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] in5,
  input  logic [1:0] in10,
  output logic [1:0] refuse,
  output logic       disp_req,
  output logic       disp_lane,
  input  logic       disp_ack,
  output logic       back5_req,
  input  logic       back5_ack,
  output logic [1:0] done,
  output logic       fault
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t          state;
  state_t          next_state;
  logic [1:0]      pending;
  logic [1:0]      clear_lane;
  logic [2:0]      credit0;
  logic [2:0]      credit1;
  logic [2:0]      served_credit;
  logic            lane_q;
  logic            ptr;
  logic            grant_lane;
  logic            tmo_hit;
  logic            tmo_fire;
  logic [TW-1:0]   tmo_cnt;

  vend_lane #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)) u_lane0 (
    .clk     (clk),
    .reset   (reset),
    .in5     (in5[0]),
    .in10    (in10[0]),
    .clear   (clear_lane[0]),
    .credit  (credit0),
    .pending (pending[0]),
    .refuse  (refuse[0])
  );

  vend_lane #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT)) u_lane1 (
    .clk     (clk),
    .reset   (reset),
    .in5     (in5[1]),
    .in10    (in10[1]),
    .clear   (clear_lane[1]),
    .credit  (credit1),
    .pending (pending[1]),
    .refuse  (refuse[1])
  );

  // The pointer only matters when both lanes wait at once.
  always_comb begin
    grant_lane    = (pending == 2'b11) ? ptr : pending[1];
    served_credit = lane_q ? credit1 : credit0;
    tmo_hit       = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // An acknowledge in the last allowed cycle still wins over the timeout.
  always_comb begin
    next_state = state;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) next_state = DISPENSE;
      end
      DISPENSE: begin
        if (disp_ack) begin
          next_state = (served_credit == 3'(PRICE)) ? DONE : CHANGE;
        end else if (tmo_hit) begin
          next_state = IDLE;
          tmo_fire   = 1'b1;
        end
      end
      CHANGE: begin
        if (back5_ack) begin
          next_state = DONE;
        end else if (tmo_hit) begin
          next_state = IDLE;
          tmo_fire   = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    disp_req   = (state == DISPENSE);
    back5_req  = (state == CHANGE);
    disp_lane  = lane_q;
    done       = '0;
    if (state == DONE) done[lane_q] = 1'b1;
    clear_lane = done;
  end

  // The timeout counter restarts on every state change so that DISPENSE and
  // CHANGE each get the full acknowledge window.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q  <= 1'b0;
      ptr     <= 1'b0;
      tmo_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      if (state == IDLE && |pending) lane_q <= grant_lane;
      if (state == DONE || tmo_fire) ptr <= ~ptr;
      if (tmo_fire) fault <= 1'b1;
      if (next_state != state) begin
        tmo_cnt <= '0;
      end else if (state == DISPENSE || state == CHANGE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed self-checking bench for vend_arbiter with default parameters
// (price 3 coins, ceiling 4 coins, acknowledge window 15 cycles).
module tb_vend_arbiter;
  import vend_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in5;
  logic [1:0] in10;
  logic [1:0] refuse;
  logic       disp_req;
  logic       disp_lane;
  logic       disp_ack;
  logic       back5_req;
  logic       back5_ack;
  logic [1:0] done;
  logic       fault;

  int tests_run = 0;
  int tests_failed = 0;

  vend_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .in5       (in5),
    .in10      (in10),
    .refuse    (refuse),
    .disp_req  (disp_req),
    .disp_lane (disp_lane),
    .disp_ack  (disp_ack),
    .back5_req (back5_req),
    .back5_ack (back5_ack),
    .done      (done),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1; in5 = '0; in10 = '0; disp_ack = 1'b0; back5_ack = 1'b0;
    step;
    step;
    reset = 1'b0;
  endtask

  task automatic wait_disp(output logic ok);
    int n;
    n = 0;
    while (!disp_req && n < 30) begin
      step;
      n++;
    end
    ok = disp_req;
  endtask

  // Acknowledges each request once it has been high for ack_delay cycles and
  // runs until a done pulse is seen; cycles counts edges before the pulse.
  task automatic serve(input int ack_delay, output logic got_done, output logic saw_disp,
                       output logic saw_back5, output logic lane_seen,
                       output logic [1:0] done_seen, output int cycles);
    int age, kind, prev_kind;
    got_done = 0; saw_disp = 0; saw_back5 = 0; lane_seen = 0; done_seen = '0;
    cycles = 0; age = 0; prev_kind = 0;
    while (!got_done && cycles < 80) begin
      if (done != 2'b00) begin
        got_done = 1; done_seen = done; disp_ack = 0; back5_ack = 0;
        step;
      end else begin
        kind = disp_req ? 1 : (back5_req ? 2 : 0);
        if (kind != prev_kind) age = 0;
        prev_kind = kind;
        if (disp_req) begin saw_disp = 1; lane_seen = disp_lane; end
        if (back5_req) saw_back5 = 1;
        disp_ack  = disp_req && (age >= ack_delay);
        back5_ack = back5_req && (age >= ack_delay);
        if (kind != 0) age++;
        step;
        cycles++;
      end
    end
    disp_ack = 0; back5_ack = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in5 = 2'b11; in10 = 2'b00; disp_ack = 1'b0; back5_ack = 1'b0;
    step;
    tests_run++; if (refuse !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_refuse: got %0h expected 0", refuse); end
    reset = 1'b0; in5 = 2'b00;
    step;
    tests_run++; if (refuse !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_coin_refuse: got %0h expected 0", refuse); end
    tests_run++; if (dut.u_lane0.credit !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_credit0: got %0d expected 0", dut.u_lane0.credit); end
    tests_run++; if (dut.u_lane1.credit !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_credit1: got %0d expected 0", dut.u_lane1.credit); end
    tests_run++; if ({disp_req, back5_req, disp_lane, fault} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_outputs: got %b expected 0000", {disp_req, back5_req, disp_lane, fault}); end
    tests_run++; if (done !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_done: got %0h expected 0", done); end
    disp_ack = 1'b1; back5_ack = 1'b1;
    step;
    step;
    disp_ack = 1'b0; back5_ack = 1'b0;
    tests_run++; if ({disp_req, back5_req, done} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL stray_ack: got %b expected 0000", {disp_req, back5_req, done}); end
  endtask

  task automatic test_lane0_exact;
    logic got, sd, sb, ln; logic [1:0] dv; int cyc;
    apply_reset;
    for (int i = 0; i < 3; i++) begin in5 = 2'b01; step; end
    in5 = 2'b00;
    tests_run++; if (dut.u_lane0.credit !== 3'd3) begin tests_failed++; $display("[TB] FAIL l0_credit3: got %0d expected 3", dut.u_lane0.credit); end
    serve(0, got, sd, sb, ln, dv, cyc);
    tests_run++; if ({got, sd, sb, ln} !== 4'b1100) begin tests_failed++; $display("[TB] FAIL l0_flow done/disp/back5/lane: got %b expected 1100", {got, sd, sb, ln}); end
    tests_run++; if (dv !== 2'b01) begin tests_failed++; $display("[TB] FAIL l0_done_vec: got %0h expected 1", dv); end
    tests_run++; if (cyc + 1 !== 4) begin tests_failed++; $display("[TB] FAIL l0_latency: got %0d expected 4", cyc + 1); end
    tests_run++; if (done !== 2'b00) begin tests_failed++; $display("[TB] FAIL l0_done_width: got %0h expected 0", done); end
    tests_run++; if (dut.u_lane0.credit !== 3'd0) begin tests_failed++; $display("[TB] FAIL l0_credit_cleared: got %0d expected 0", dut.u_lane0.credit); end
  endtask

  task automatic test_lane1_change;
    logic got, sd, sb, ln; logic [1:0] dv; int cyc;
    apply_reset;
    in10 = 2'b10; step; step;
    in10 = 2'b00; step;
    in10 = 2'b10; step;
    tests_run++; if (refuse !== 2'b10) begin tests_failed++; $display("[TB] FAIL l1_pending_refuse: got %0h expected 2", refuse); end
    tests_run++; if (dut.u_lane1.credit !== 3'd4) begin tests_failed++; $display("[TB] FAIL l1_credit4: got %0d expected 4", dut.u_lane1.credit); end
    in10 = 2'b00; step;
    tests_run++; if (refuse !== 2'b00) begin tests_failed++; $display("[TB] FAIL l1_refuse_width: got %0h expected 0", refuse); end
    serve(2, got, sd, sb, ln, dv, cyc);
    tests_run++; if ({got, sd, sb, ln} !== 4'b1111) begin tests_failed++; $display("[TB] FAIL l1_flow done/disp/back5/lane: got %b expected 1111", {got, sd, sb, ln}); end
    tests_run++; if (dv !== 2'b10) begin tests_failed++; $display("[TB] FAIL l1_done_vec: got %0h expected 2", dv); end
    tests_run++; if ({dut.u_lane1.credit, fault} !== 4'b0000) begin tests_failed++; $display("[TB] FAIL l1_after credit/fault: got %b expected 0000", {dut.u_lane1.credit, fault}); end
  endtask

  task automatic test_round_robin;
    logic got, sd, sb, ln; logic [1:0] dv; int cyc;
    apply_reset;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin in5 = 2'b11; step; end
      in5 = 2'b00;
      serve(0, got, sd, sb, ln, dv, cyc);
      tests_run++; if ({got, ln, dv} !== 4'b1001) begin tests_failed++; $display("[TB] FAIL rr_first round %0d: got %b expected 1001", r, {got, ln, dv}); end
      serve(0, got, sd, sb, ln, dv, cyc);
      tests_run++; if ({got, ln, dv} !== 4'b1110) begin tests_failed++; $display("[TB] FAIL rr_second round %0d: got %b expected 1110", r, {got, ln, dv}); end
    end
  endtask

  task automatic test_coin_boundaries;
    apply_reset;
    in5 = 2'b01; in10 = 2'b01; step;
    in5 = 2'b00; in10 = 2'b00;
    tests_run++; if (refuse !== 2'b01) begin tests_failed++; $display("[TB] FAIL dual_coin_refuse: got %0h expected 1", refuse); end
    tests_run++; if (dut.u_lane0.credit !== 3'd0) begin tests_failed++; $display("[TB] FAIL dual_coin_credit: got %0d expected 0", dut.u_lane0.credit); end
    step;
    tests_run++; if (refuse !== 2'b00) begin tests_failed++; $display("[TB] FAIL dual_coin_width: got %0h expected 0", refuse); end
    in10 = 2'b01; step; step; step;
    in10 = 2'b00;
    tests_run++; if (refuse !== 2'b01) begin tests_failed++; $display("[TB] FAIL ceiling_refuse: got %0h expected 1", refuse); end
    tests_run++; if (dut.u_lane0.credit !== 3'd4) begin tests_failed++; $display("[TB] FAIL ceiling_credit: got %0d expected 4", dut.u_lane0.credit); end
    apply_reset;
    in10 = 2'b01; step;
    in10 = 2'b00; in5 = 2'b01; step;
    in5 = 2'b00; step;
    in5 = 2'b01; step;
    in5 = 2'b00;
    tests_run++; if (refuse !== 2'b01) begin tests_failed++; $display("[TB] FAIL pending_in5_refuse: got %0h expected 1", refuse); end
    in10 = 2'b01; step;
    in10 = 2'b00;
    tests_run++; if (refuse !== 2'b01) begin tests_failed++; $display("[TB] FAIL pending_in10_refuse: got %0h expected 1", refuse); end
    tests_run++; if (dut.u_lane0.credit !== 3'd3) begin tests_failed++; $display("[TB] FAIL pending_credit: got %0d expected 3", dut.u_lane0.credit); end
  endtask

  task automatic test_concurrent;
    logic ok, got, sd, sb, ln; logic [1:0] dv; int cyc;
    apply_reset;
    for (int i = 0; i < 3; i++) begin in5 = 2'b01; step; end
    in5 = 2'b00;
    wait_disp(ok);
    tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL conc_disp_req: got %b expected 1", ok); end
    in5 = 2'b10; step;
    in5 = 2'b00;
    tests_run++; if ({refuse, dut.u_lane1.credit} !== 5'b00001) begin tests_failed++; $display("[TB] FAIL conc_lane1_accept refuse/credit: got %b expected 00001", {refuse, dut.u_lane1.credit}); end
    serve(0, got, sd, sb, ln, dv, cyc);
    tests_run++; if ({got, dv, dut.u_lane1.credit} !== 6'b101001) begin tests_failed++; $display("[TB] FAIL conc_serve done/vec/credit1: got %b expected 101001", {got, dv, dut.u_lane1.credit}); end
  endtask

  task automatic test_timeout;
    logic ok, got, sd, sb, ln; logic [1:0] dv; int cyc, n;
    apply_reset;
    for (int i = 0; i < 3; i++) begin in5 = 2'b01; step; end
    in5 = 2'b00;
    back5_ack = 1'b1;
    wait_disp(ok);
    n = 0;
    while (disp_req && n < 40) begin step; n++; end
    back5_ack = 1'b0;
    tests_run++; if (n !== 15) begin tests_failed++; $display("[TB] FAIL tmo_req_cycles: got %0d expected 15", n); end
    tests_run++; if ({ok, disp_req, fault} !== 3'b101) begin tests_failed++; $display("[TB] FAIL tmo_state ok/req/fault: got %b expected 101", {ok, disp_req, fault}); end
    tests_run++; if (dut.u_lane0.credit !== 3'd3) begin tests_failed++; $display("[TB] FAIL tmo_credit_kept: got %0d expected 3", dut.u_lane0.credit); end
    wait_disp(ok);
    tests_run++; if ({ok, disp_lane} !== 2'b10) begin tests_failed++; $display("[TB] FAIL tmo_reserve ok/lane: got %b expected 10", {ok, disp_lane}); end
    serve(0, got, sd, sb, ln, dv, cyc);
    tests_run++; if ({got, dv, fault} !== 4'b1011) begin tests_failed++; $display("[TB] FAIL tmo_complete done/vec/fault: got %b expected 1011", {got, dv, fault}); end
  endtask

  task automatic test_reset_mid_change;
    logic ok; int seen;
    apply_reset;
    in10 = 2'b10; step; step;
    in10 = 2'b00;
    wait_disp(ok);
    disp_ack = 1'b1; step;
    disp_ack = 1'b0;
    tests_run++; if ({ok, back5_req} !== 2'b11) begin tests_failed++; $display("[TB] FAIL mid_in_change: got %b expected 11", {ok, back5_req}); end
    reset = 1'b1; step;
    reset = 1'b0;
    tests_run++; if (dut.state !== IDLE) begin tests_failed++; $display("[TB] FAIL mid_state: got %0d expected %0d", dut.state, IDLE); end
    tests_run++; if ({disp_req, back5_req, disp_lane, done, refuse} !== 7'b0) begin tests_failed++; $display("[TB] FAIL mid_outputs: got %b expected 0000000", {disp_req, back5_req, disp_lane, done, refuse}); end
    tests_run++; if (dut.u_lane1.credit !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_credit: got %0d expected 0", dut.u_lane1.credit); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (done != 2'b00 || disp_req || back5_req) seen++;
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("[TB] FAIL mid_no_done: got %0d activity cycles expected 0", seen); end
  endtask

  initial begin
    test_reset;
    test_lane0_exact;
    test_lane1_change;
    test_round_robin;
    test_coin_boundaries;
    test_concurrent;
    test_timeout;
    test_reset_mid_change;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
